// File: rtl/param_icache.sv
// param_icache: N-way set-associative instruction cache with multi-word
// block fill, per-set round-robin replacement and single-cycle flush.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module param_icache #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [31:0]       imemload,
  input  logic              iflush,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [31:0]       iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned WO  = $clog2(BLOCK_WORDS);
  localparam int unsigned IX  = $clog2(SETS);
  localparam int unsigned TW  = ADDR_W - 2 - WO - IX;
  localparam int unsigned WOW = (WO > 0) ? WO : 1;
  localparam int unsigned WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CW  = $clog2(WAYS + 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q;
  logic [WOW-1:0]    cnt_q;
  logic              iren_q;
  logic [ADDR_W-1:0] iaddr_q;
  logic [IX-1:0]     fill_idx_q;
  logic [TW-1:0]     fill_tag_q;
  logic [WW-1:0]     victim_q;
  logic              victim_inv_q;

  logic [31:0]       data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [TW-1:0]     tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WW-1:0]     ptr_q   [SETS];

  logic [WOW-1:0]    req_off;
  logic [IX-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic [CW-1:0]     match_cnt;
  logic [WW-1:0]     hit_way;
  logic              lookup_hit;
  logic              inv_found;
  logic [WW-1:0]     inv_way;
  logic              miss_start;
  logic              last_word;
  logic [WW-1:0]     ptr_next;
  logic              unused_bits;

  // Address split: byte offset, word offset, set index, tag
  assign req_off     = WOW'((imemaddr >> 2) & ADDR_W'(BLOCK_WORDS - 1));
  assign req_idx     = IX'(imemaddr >> (2 + WO));
  assign req_tag     = TW'(imemaddr >> (2 + WO + IX));
  assign unused_bits = ^imemaddr[1:0];

  // Tag compare across the indexed set plus lowest-invalid-way search
  always_comb begin
    match_cnt = '0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        match_cnt = match_cnt + CW'(1);
        hit_way   = WW'(w);
      end
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    lookup_hit = (match_cnt == CW'(1));
  end

  assign ihit       = (state_q == IDLE) && imemREN && !iflush && lookup_hit;
  assign imemload   = ihit ? data_q[hit_way][req_idx][req_off] : 32'h0;
  assign miss_start = (state_q == IDLE) && imemREN && !iflush && !lookup_hit;
  assign last_word  = (cnt_q == WOW'(BLOCK_WORDS - 1));
  assign ptr_next   = (ptr_q[fill_idx_q] == WW'(WAYS - 1)) ? '0
                                                           : ptr_q[fill_idx_q] + WW'(1);
  assign iREN       = iren_q;
  assign iaddr      = iaddr_q;

  // Fill controller, valid bits and replacement pointers; flush wins over everything
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      iren_q       <= 1'b0;
      iaddr_q      <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      victim_q     <= '0;
      victim_inv_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (iflush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iren_q  <= 1'b0;
      iaddr_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            iren_q       <= 1'b1;
            iaddr_q      <= imemaddr & ~ADDR_W'(BLOCK_WORDS * 4 - 1);
            fill_idx_q   <= req_idx;
            fill_tag_q   <= req_tag;
            victim_q     <= inv_found ? inv_way : ptr_q[req_idx];
            victim_inv_q <= inv_found;
          end
        end
        FILL: begin
          if (!iwait) begin
            if (last_word) begin
              state_q                       <= IDLE;
              cnt_q                         <= '0;
              iren_q                        <= 1'b0;
              iaddr_q                       <= '0;
              valid_q[fill_idx_q][victim_q] <= 1'b1;
              if (!victim_inv_q) begin
                ptr_q[fill_idx_q] <= ptr_next;
              end
            end else begin
              cnt_q   <= cnt_q + WOW'(1);
              iaddr_q <= iaddr_q + ADDR_W'(4);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag storage; contents are qualified by valid bits so no reset
  always_ff @(posedge CLK) begin
    if ((state_q == FILL) && !iflush && !iwait) begin
      data_q[victim_q][fill_idx_q][cnt_q] <= iload;
      if (last_word) begin
        tag_q[victim_q][fill_idx_q] <= fill_tag_q;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters, untouched by flush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_icache.sv
// Scoreboard bench for param_icache: transaction-level cache model predicts
// hits/misses, fill address sequences and returned words.
module tb_param_icache;

  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 8;
  localparam int unsigned BW   = 2;
  localparam int unsigned WO   = $clog2(BW);
  localparam int unsigned IX   = $clog2(SETS);

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        iflush = 1'b0;
  logic        iwait = 1'b0;
  logic [31:0] iload = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  param_icache #(.WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  logic [31:0] exp_q[$];
  logic [31:0] fill_q[$];
  int total = 0;
  int bad = 0;
  int mode = 0;      // 0: no wait, 1: random wait, 2: three waits per word
  bit hold_mem = 1'b0;
  int wcnt = 0;
  logic [31:0] mon_exp;

  bit          mvalid [SETS][WAYS];
  int unsigned mtag   [SETS][WAYS];
  int unsigned mptr   [SETS];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h40) return 32'h1111_1111;
    if (a == 32'h44) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
    end
  endfunction

  // Returns 1 on a miss; installs the line and queues its fill addresses
  function automatic bit model_access(input logic [31:0] a);
    int unsigned idx = (a >> (2 + WO)) % SETS;
    int unsigned tg  = a >> (2 + WO + IX);
    int v = -1;
    logic [31:0] base;
    for (int w = 0; w < WAYS; w++)
      if (mvalid[idx][w] && mtag[idx][w] == tg) return 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !mvalid[idx][w]) v = w;
    if (v < 0) begin
      v = int'(mptr[idx]);
      mptr[idx] = (mptr[idx] + 1) % WAYS;
    end
    mvalid[idx][v] = 1'b1;
    mtag[idx][v]   = tg;
    base = a & ~(BW * 4 - 1);
    for (int i = 0; i < BW; i++) fill_q.push_back(base + 32'(4 * i));
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: hit data against the scoreboard, memory requests against expected fill addresses
  always @(negedge CLK) begin
    if (ihit === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL hit_unexpected: got ihit=1 data=%h required no hit", imemload);
      end else begin
        mon_exp = exp_q.pop_front();
        if (imemload !== mon_exp) begin
          bad++;
          $display("FAIL hit_data: got %h required %h", imemload, mon_exp);
        end
      end
    end
    if (iREN === 1'b1) begin
      if (fill_q.size() == 0) begin
        if (iwait == 1'b0) begin
          total++;
          bad++;
          $display("FAIL fetch_unexpected: got iaddr=%h required no request", iaddr);
        end
      end else begin
        total++;
        if (iaddr !== fill_q[0]) begin
          bad++;
          $display("FAIL fill_addr: got %h required %h", iaddr, fill_q[0]);
        end
        if (iwait == 1'b0) void'(fill_q.pop_front());
      end
    end
  end

  // Memory responder
  always @(posedge CLK) begin
    #1;
    if (hold_mem) iwait = 1'b1;
    else if (iREN !== 1'b1) iwait = 1'b0;
    else if (mode == 0) iwait = 1'b0;
    else if (mode == 1) iwait = ($urandom_range(0, 2) == 0);
    else if (wcnt < 3) begin
      iwait = 1'b1;
      wcnt++;
    end else begin
      iwait = 1'b0;
      wcnt = 0;
    end
    iload = mem_rd(iaddr);
  end

  task automatic wait_hit(output int k);
    k = 0;
    forever begin
      @(negedge CLK);
      if (ihit === 1'b1) break;
      k++;
      if (k > 400) begin
        total++;
        bad++;
        $display("FAIL hit_timeout: got no ihit after %0d cycles required ihit", k);
        exp_q.delete();
        break;
      end
    end
  endtask

  function automatic int exp_lat(input bit miss);
    if (!miss) return 0;
    if (mode == 2) return 1 + BW * 4;
    return 1 + BW;
  endfunction

  task automatic fetch(input logic [31:0] a);
    bit miss;
    int k;
    miss = model_access(a);
    exp_q.push_back(mem_rd(a & ~32'h3));
    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = a;
    wait_hit(k);
    if (mode == 1 && miss) chk("miss_lat_min", 32'(k >= int'(1 + BW)), 32'd1);
    else if (miss) chk("miss_lat", 32'(k), 32'(exp_lat(miss)));
    else chk("hit_lat", 32'(k), 32'(exp_lat(miss)));
  endtask

  task automatic do_flush(input logic [31:0] a);
    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = a;
    iflush = 1'b1;
    @(negedge CLK);
    chk("flush_ihit", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    iflush = 1'b0;
    imemREN = 1'b0;
    model_clear();
  endtask

  task automatic flush_abort(input logic [31:0] a);
    int k = 0;
    fill_q.push_back(a & ~(BW * 4 - 1));
    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = a;
    do begin
      @(negedge CLK); #1;
      k++;
    end while (fill_q.size() != 0 && k < 50);
    chk("abort_first_word", 32'(fill_q.size()), 32'd0);
    @(posedge CLK);
    hold_mem = 1'b1;
    #1;
    iflush = 1'b1;
    imemREN = 1'b0;
    @(posedge CLK); #1;
    iflush = 1'b0;
    hold_mem = 1'b0;
    @(negedge CLK);
    chk("abort_iren", 32'(iREN), 32'd0);
    fill_q.delete();
    model_clear();
  endtask

  task automatic change_addr(input logic [31:0] a, input logic [31:0] b);
    bit miss;
    int k = 0;
    miss = model_access(a);
    chk("chg_first_miss", 32'(miss), 32'd1);
    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = a;
    do begin
      @(negedge CLK); #1;
      k++;
    end while (fill_q.size() != BW - 1 && k < 50);
    chk("chg_first_word", 32'(fill_q.size()), 32'(BW - 1));
    @(posedge CLK); #1;
    imemaddr = b;
    miss = model_access(b);
    exp_q.push_back(mem_rd(b & ~32'h3));
    wait_hit(k);
    chk("chg_lat", 32'(k), 32'(2 * BW));
  endtask

  task automatic async_reset(input logic [31:0] a);
    int k = 0;
    hold_mem = 1'b1;
    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = a;
    do begin
      @(negedge CLK);
      k++;
    end while (iREN !== 1'b1 && k < 50);
    chk("rst_fill_started", 32'(iREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    hold_mem = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge CLK);
    chk("reset_ihit", 32'(ihit), 32'd0);
    chk("reset_imemload", imemload, 32'd0);
    chk("reset_iren", 32'(iREN), 32'd0);
    chk("reset_iaddr", iaddr, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // First fill and same-line hit
    mode = 0;
    fetch(32'h40);
    fetch(32'h44);
`ifdef ICACHE_STATS_EN
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK);
    chk("stats_hit", hit_count, 32'd2);
    chk("stats_miss", miss_count, 32'd1);
`endif

    // Round-robin replacement within one set
    do_flush(32'h40);
    fetch(32'h000);
    fetch(32'h040);
    fetch(32'h080);
    fetch(32'h040);
    fetch(32'h000);
    fetch(32'h080);
    fetch(32'h040);

    // Slow memory
    mode = 2;
    fetch(32'h200);
    fetch(32'h204);
    mode = 0;

    // Flush in the middle of a fill
    flush_abort(32'h300);
    fetch(32'h300);
    fetch(32'h040);
    fetch(32'h040);

    // Request address moved during a fill
    do_flush(32'h40);
    change_addr(32'h40, 32'h100);
    fetch(32'h40);
    fetch(32'h104);

    // Asynchronous reset during a fill
    async_reset(32'h500);
    fetch(32'h40);
    fetch(32'h500);

    // Random traffic with random memory stalls
    mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) do_flush(32'($urandom_range(0, 255)) << 2);
      else fetch(32'($urandom_range(0, 255)) << 2);
    end
    mode = 0;

    @(posedge CLK); #1;
    imemREN = 1'b0;
    repeat (5) @(negedge CLK);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("fill_q_drained", 32'(fill_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required $finish");
    $fatal(1, "watchdog");
  end

endmodule
